game_status_counter: RTL and testbench

Upstream producer of the per-game status values that the on-screen information overlay draws. It tracks the active game mode (classic or infinity), the player HP in classic mode, and the remaining-time countdown in infinity mode. It drives the overlay's mode enables and its HP_print/time_print bars, and it flags game over to the top-level mode controller.

---
 rtl/game_status_counter_pkg.sv | 45 ++++
 rtl/game_status_counter_tick_prescaler.sv | 36 +++
 rtl/game_status_counter.sv | 111 +++++++++++
 tb/tb_game_status_counter.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/game_status_counter_pkg.sv
// Shared encodings and bar-scaling constants for the game status counter and the overlay.
// Pure declarations: no logic, no latency.
package game_status_counter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_OVER = 2'd2
    } state_t;

    typedef enum logic {
        MODE_CLASSIC  = 1'b0,
        MODE_INFINITY = 1'b1
    } mode_t;

    // Overlay bar segment counts; the overlay scales its bars against these.
    localparam int HP_MAX   = 9;
    localparam int TIME_MAX = 18;

    localparam int HP_W   = 5;
    localparam int TIME_W = 6;

    // One counter update: simultaneous inc and dec cancel, inc saturates at
    // max_val before adding, dec never goes below zero.
    function automatic int step_count(
        input int   val,
        input logic inc,
        input logic dec,
        input int   max_val
    );
        int res;
        res = val;
        if (inc && !dec) begin
            if (val < max_val) begin
                res = val + 1;
            end
        end else if (dec && !inc) begin
            if (val >= 1) begin
                res = val - 1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/game_status_counter_tick_prescaler.sv
// Free-running divider that emits a one-cycle tick every TICK_CYCLES enabled cycles.
// Tick is combinational from the registered count; clear has priority over enable; no backpressure.
module game_status_counter_tick_prescaler #(
    parameter int TICK_CYCLES = 100000000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_CYCLES - 1);

    logic [CW-1:0] count;

    // Tick is not masked by clear: the final tick may be the very event
    // that causes the state change driving clear.
    assign tick = enable && (count == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            if (count == LAST) begin
                count <= '0;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/game_status_counter.sv
// Game mode / HP / countdown tracker feeding the overlay bars and the top-level mode controller.
// Every output is registered and reflects an input one cycle later; inputs are pulses, no backpressure.
module game_status_counter
    import game_status_counter_pkg::*;
#(
    parameter int HP_INIT     = 8,
    parameter int HP_MAX      = game_status_counter_pkg::HP_MAX,
    parameter int TIME_INIT   = 18,
    parameter int TIME_MAX    = game_status_counter_pkg::TIME_MAX,
    parameter int TICK_CYCLES = 100000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              mode_sel,
    input  logic              abort,
    input  logic              hit,
    input  logic              bonus,
    output logic              enable_game_classic,
    output logic              enable_game_infinity,
    output logic [HP_W-1:0]   HP_print,
    output logic [TIME_W-1:0] time_print,
    output logic              game_over,
    output logic              over_pulse
);

    state_t            state_q, state_d;
    mode_t             mode_q, mode_d;
    logic [HP_W-1:0]   hp_q, hp_d, hp_next;
    logic [TIME_W-1:0] time_q, time_d, time_next;
    logic              tick;
    logic              pre_clear;
    logic              pre_enable;

    assign pre_enable = (state_q == ST_RUN) && (mode_q == MODE_INFINITY);
    assign pre_clear  = (state_d != state_q);

    game_status_counter_tick_prescaler #(
        .TICK_CYCLES (TICK_CYCLES)
    ) u_prescaler (
        .clk    (clk),
        .rst    (rst),
        .clear  (pre_clear),
        .enable (pre_enable),
        .tick   (tick)
    );

    assign hp_next   = HP_W'(step_count(int'(hp_q), bonus, hit, HP_MAX));
    assign time_next = TIME_W'(step_count(int'(time_q), bonus, tick, TIME_MAX));

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        hp_d    = hp_q;
        time_d  = time_q;

        if (abort) begin
            state_d = ST_IDLE;
            hp_d    = '0;
            time_d  = '0;
        end else if (start && (state_q != ST_RUN)) begin
            state_d = ST_RUN;
            mode_d  = mode_t'(mode_sel);
            if (mode_sel) begin
                hp_d   = '0;
                time_d = TIME_W'(TIME_INIT);
            end else begin
                hp_d   = HP_W'(HP_INIT);
                time_d = '0;
            end
        end else if (state_q == ST_RUN) begin
            if (mode_q == MODE_CLASSIC) begin
                hp_d = hp_next;
                if (hp_next == '0) begin
                    state_d = ST_OVER;
                end
            end else begin
                time_d = time_next;
                if (time_next == '0) begin
                    state_d = ST_OVER;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q              <= ST_IDLE;
            mode_q               <= MODE_CLASSIC;
            hp_q                 <= '0;
            time_q               <= '0;
            enable_game_classic  <= 1'b0;
            enable_game_infinity <= 1'b0;
            game_over            <= 1'b0;
            over_pulse           <= 1'b0;
        end else begin
            state_q              <= state_d;
            mode_q               <= mode_d;
            hp_q                 <= hp_d;
            time_q               <= time_d;
            enable_game_classic  <= (state_d != ST_IDLE) && (mode_d == MODE_CLASSIC);
            enable_game_infinity <= (state_d != ST_IDLE) && (mode_d == MODE_INFINITY);
            game_over            <= (state_d == ST_OVER);
            over_pulse           <= (state_q == ST_RUN) && (state_d == ST_OVER);
        end
    end

    assign HP_print   = hp_q;
    assign time_print = time_q;

endmodule

// File: tb/tb_game_status_counter.sv
// Randomized bench for game_status_counter against a cycle-level game model.
module tb_game_status_counter;

    localparam int TICK   = 4;
    localparam int HP0    = 8;
    localparam int HPMAX  = 9;
    localparam int T0     = 18;
    localparam int TMAX   = 18;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, mode_sel, abort, hit, bonus;
    logic       enable_game_classic, enable_game_infinity;
    logic [4:0] HP_print;
    logic [5:0] time_print;
    logic       game_over, over_pulse;

    always #5 clk = ~clk;

    game_status_counter #(
        .HP_INIT     (HP0),
        .HP_MAX      (HPMAX),
        .TIME_INIT   (T0),
        .TIME_MAX    (TMAX),
        .TICK_CYCLES (TICK)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .start                (start),
        .mode_sel             (mode_sel),
        .abort                (abort),
        .hit                  (hit),
        .bonus                (bonus),
        .enable_game_classic  (enable_game_classic),
        .enable_game_infinity (enable_game_infinity),
        .HP_print             (HP_print),
        .time_print           (time_print),
        .game_over            (game_over),
        .over_pulse           (over_pulse)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int pulse_cnt = 0;

    // Model: phase 0 idle, 1 playing, 2 over; run_cyc = cycles spent playing since entry.
    int m_phase, m_mode, m_hp, m_time, m_run_cyc, m_pulse;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_mode = 0; m_hp = 0; m_time = 0; m_run_cyc = 0; m_pulse = 0;
    endtask

    task automatic model_step(input bit s, input bit ms, input bit a, input bit h, input bit b);
        bit tick;
        tick = (m_phase == 1) && (m_mode == 1) && ((m_run_cyc % TICK) == TICK - 1);
        m_pulse = 0;
        if (a) begin
            m_phase = 0; m_hp = 0; m_time = 0;
        end else if (s && m_phase != 1) begin
            m_phase = 1; m_mode = ms; m_run_cyc = 0;
            m_hp   = ms ? 0 : HP0;
            m_time = ms ? T0 : 0;
        end else if (m_phase == 1) begin
            m_run_cyc++;
            if (m_mode == 0) begin
                if (h && !b)      m_hp = (m_hp > 0) ? m_hp - 1 : 0;
                else if (b && !h) m_hp = (m_hp < HPMAX) ? m_hp + 1 : HPMAX;
                if (m_hp == 0) begin m_phase = 2; m_pulse = 1; end
            end else begin
                if (tick && !b)      m_time = (m_time > 0) ? m_time - 1 : 0;
                else if (b && !tick) m_time = (m_time < TMAX) ? m_time + 1 : TMAX;
                if (m_time == 0) begin m_phase = 2; m_pulse = 1; end
            end
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".en_classic"},  int'(enable_game_classic),  int'(m_phase != 0 && m_mode == 0));
        check({tag, ".en_infinity"}, int'(enable_game_infinity), int'(m_phase != 0 && m_mode == 1));
        check({tag, ".hp"},          int'(HP_print),   m_hp);
        check({tag, ".time"},        int'(time_print), m_time);
        check({tag, ".game_over"},   int'(game_over),  int'(m_phase == 2));
        check({tag, ".over_pulse"},  int'(over_pulse), m_pulse);
    endtask

    // One clock: drive at negedge, update model at posedge, compare at next negedge.
    task automatic cyc(input bit s, input bit ms, input bit a, input bit h, input bit b, input string tag);
        start = s; mode_sel = ms; abort = a; hit = h; bonus = b;
        @(posedge clk);
        model_step(s, ms, a, h, b);
        @(negedge clk);
        start = 0; abort = 0; hit = 0; bonus = 0;
        pulse_cnt += int'(over_pulse);
        compare_all(tag);
    endtask

    task automatic async_reset(input string tag);
        rst = 1'b1;
        #1;
        check({tag, ".en_classic"},  int'(enable_game_classic), 0);
        check({tag, ".en_infinity"}, int'(enable_game_infinity), 0);
        check({tag, ".hp"},          int'(HP_print), 0);
        check({tag, ".time"},        int'(time_print), 0);
        check({tag, ".game_over"},   int'(game_over), 0);
        check({tag, ".over_pulse"},  int'(over_pulse), 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        start = 0; mode_sel = 0; abort = 0; hit = 0; bonus = 0;
        rst = 1'b0;
        model_reset();
        #2 rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        compare_all("reset");
        rst = 1'b0;
        @(negedge clk);

        // Classic: start, count down to OVER, extra hits stay at 0.
        cyc(1, 0, 0, 0, 0, "cl_start");
        check("cl_hp_init", int'(HP_print), 8);
        pulse_cnt = 0;
        for (int i = 0; i < 8; i++) cyc(0, 0, 0, 1, 0, "cl_hit");
        check("cl_over_level", int'(game_over), 1);
        cyc(0, 0, 0, 1, 0, "cl_hit_over");
        cyc(0, 0, 0, 1, 0, "cl_hit_over");
        check("cl_over_pulses", pulse_cnt, 1);
        check("cl_hp_floor", int'(HP_print), 0);

        // Classic saturation from a restart in OVER.
        cyc(1, 0, 0, 0, 0, "cl_restart");
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 1, "cl_bonus");
        check("cl_hp_sat", int'(HP_print), 9);
        cyc(0, 0, 0, 1, 1, "cl_hit_bonus");
        check("cl_hp_hit_bonus", int'(HP_print), 9);
        cyc(1, 1, 0, 0, 0, "cl_start_in_run");

        // Abort returns to idle next cycle with no over pulse.
        pulse_cnt = 0;
        cyc(0, 0, 1, 0, 0, "abort");
        check("abort_pulses", pulse_cnt, 0);

        // Infinity: 72 cycles to OVER, hits ignored, bonus at full stays full.
        pulse_cnt = 0;
        cyc(1, 1, 0, 0, 0, "inf_start");
        check("inf_time_init", int'(time_print), 18);
        cyc(0, 0, 0, 0, 1, "inf_bonus_full");
        check("inf_bonus_sat", int'(time_print), 18);
        for (int i = 0; i < 70; i++) cyc(0, 0, 0, 1'($urandom_range(0, 1)), 0, "inf_run");
        check("inf_not_over_yet", int'(game_over), 0);
        cyc(0, 0, 0, 1, 0, "inf_run");
        check("inf_over_at_72", int'(game_over), 1);
        check("inf_time_zero", int'(time_print), 0);
        check("inf_over_pulses", pulse_cnt, 1);
        for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0, 1, "inf_frozen");

        // Restart infinity from OVER.
        cyc(1, 1, 0, 0, 0, "inf_restart");
        check("inf_restart_time", int'(time_print), 18);
        check("inf_restart_en_c", int'(enable_game_classic), 0);
        check("inf_restart_en_i", int'(enable_game_infinity), 1);
        for (int i = 0; i < 9; i++) cyc(0, 0, 0, 0, 0, "inf_mid");

        // Asynchronous reset mid-game.
        @(posedge clk);
        #2;
        async_reset("rst_mid");
        compare_all("rst_after");

        // Randomized play.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 699) == 0) begin
                async_reset("rst_rand");
            end else begin
                cyc($urandom_range(0, 29) == 0, 1'($urandom_range(0, 1)),
                    $urandom_range(0, 149) == 0, $urandom_range(0, 3) == 0,
                    $urandom_range(0, 5) == 0, "rand");
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
